// File: rtl/aes_sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_iter -- iterative AES SubBytes stage.
//
// Accepts a 128-bit state over valid/ready, substitutes BYTES_PER_CYCLE bytes
// per clock through replicated S-box lanes, then presents the substituted
// state until the downstream consumer takes it. No overlap of accept and hold:
// one block every N+2 cycles at best (N = 16 / BYTES_PER_CYCLE).
//
// Optional macro: AES_SUB_BYTES_INV_EN adds port 'inv' (1 = inverse S-box for
// the whole block, captured at the accept edge). Undefined: forward S-box only.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   din        in   [127:0] state in, byte i = din[8i+7:8i]
//   in_valid   in   din valid
//   in_ready   out  block idle, can accept din
//   dout       out  [127:0] substituted state (meaningful while out_valid)
//   out_valid  out  dout valid, held until out_ready
//   out_ready  in   downstream accepts dout
//   inv        in   (macro only) select inverse S-box for this block
// ---------------------------------------------------------------------------

// One S-box lane: pure table lookup, combinational.
module aes_sbox_lane (
  input  logic [7:0] i_byte,
`ifdef AES_SUB_BYTES_INV_EN
  input  logic       i_inv,
`endif
  output logic [7:0] o_byte
);
  localparam logic [7:0] FWD [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
`ifdef AES_SUB_BYTES_INV_EN
  localparam logic [7:0] INV [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };
  assign o_byte = i_inv ? INV[i_byte] : FWD[i_byte];
`else
  assign o_byte = FWD[i_byte];
`endif
endmodule

module aes_sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] din,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] dout,
  output logic         out_valid,
`ifdef AES_SUB_BYTES_INV_EN
  input  logic         inv,
`endif
  input  logic         out_ready
);
  localparam int BPC = BYTES_PER_CYCLE;
  localparam int N   = 16 / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("aes_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                       r_fsm;
  logic [CW-1:0]                r_cnt;
  logic [N-1:0][BPC-1:0][7:0]   r_state;   // chunk c = bytes c*BPC .. c*BPC+BPC-1
  logic                         r_in_ready;
  logic                         r_out_valid;
  logic [BPC-1:0][7:0]          w_sel;
  logic [BPC-1:0][7:0]          w_sub;
`ifdef AES_SUB_BYTES_INV_EN
  logic                         r_inv;
`endif

  // Chunk currently being substituted.
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < N; c++)
      if (r_cnt == CW'(c)) w_sel = r_state[c];
  end

  aes_sbox_lane u_lane [BPC-1:0] (
    .i_byte (w_sel),
`ifdef AES_SUB_BYTES_INV_EN
    .i_inv  (r_inv),
`endif
    .o_byte (w_sub)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_cnt       <= '0;
      r_state     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef AES_SUB_BYTES_INV_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        S_IDLE: if (in_valid) begin
          r_state    <= din;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_fsm      <= S_BUSY;
`ifdef AES_SUB_BYTES_INV_EN
          r_inv      <= inv;
`endif
        end
        S_BUSY: begin
          for (int c = 0; c < N; c++)
            if (r_cnt == CW'(c)) r_state[c] <= w_sub;
          if (r_cnt == CW'(N - 1)) begin
            // Explicit clear: with N==1 the counter cannot wrap by itself.
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
            r_fsm       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_fsm       <= S_IDLE;
        end
        default: begin
          r_fsm       <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_state;
endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
module tb_aes_sub_bytes_iter;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [127:0]       din = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [2:0]         ir;
  logic [2:0]         ov;
  logic [2:0][127:0]  dq;
`ifdef AES_SUB_BYTES_INV_EN
  logic               inv = 1'b0;
`endif
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Three builds side by side: BPC 1, 4 (main), 16; shared stimulus.
  aes_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(ir[0]),
    .dout(dq[0]), .out_valid(ov[0]),
`ifdef AES_SUB_BYTES_INV_EN
    .inv(inv),
`endif
    .out_ready(out_ready));
  aes_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(ir[1]),
    .dout(dq[1]), .out_valid(ov[1]),
`ifdef AES_SUB_BYTES_INV_EN
    .inv(inv),
`endif
    .out_ready(out_ready));
  aes_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(ir[2]),
    .dout(dq[2]), .out_valid(ov[2]),
`ifdef AES_SUB_BYTES_INV_EN
    .inv(inv),
`endif
    .out_ready(out_ready));

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Push one block, measure latency per build, check data, then consume.
  task automatic run_blk(input string tag, input logic [127:0] d, input logic [127:0] exp,
                         input logic iv, input logic tog);
    int lat [3];
    bit seen [3];
    int exp_lat [3];
    exp_lat[0] = 16; exp_lat[1] = 4; exp_lat[2] = 1;
    for (int k = 0; k < 3; k++) begin lat[k] = -1; seen[k] = 0; end
    @(negedge clk);
    din = d; in_valid = 1'b1;
`ifdef AES_SUB_BYTES_INV_EN
    inv = iv;
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    din = ~d;
`ifdef AES_SUB_BYTES_INV_EN
    if (tog) inv = ~iv;
`endif
    for (int j = 0; j < 40; j++) begin
      for (int k = 0; k < 3; k++)
        if (!seen[k] && ov[k]) begin seen[k] = 1; lat[k] = j; end
      if (seen[0] && seen[1] && seen[2]) break;
      @(negedge clk);
`ifdef AES_SUB_BYTES_INV_EN
      if (tog) inv = ~inv;
`endif
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_lat%0d", tag, k), 128'(lat[k]), 128'(exp_lat[k]));
      chk($sformatf("%s_dout%0d", tag, k), dq[k], exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 128'(ov), 128'b0);
    chk({tag, "_ir_back"}, 128'(ir), 128'b111);
    if (iv) ;
    if (tog) ;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

  initial begin
    // 1: reset then idle
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ir", 128'(ir), 128'b111);
    chk("rst_ov", 128'(ov), 128'b0);
    chk("rst_dout", dq[1], 128'h0);

    // 2, 3: basic and FIPS-197 round-1 vector on all three widths
    run_blk("zero", 128'h0, {16{8'h63}}, 1'b0, 1'b0);
    run_blk("fips", FIPS_IN, FIPS_OUT, 1'b0, 1'b0);
    run_blk("s53", {16{8'h53}}, {16{8'hed}}, 1'b0, 1'b0);

    // 4: backpressure, new requests ignored while holding
    @(negedge clk);
    din = FIPS_IN; in_valid = 1'b1;
    @(negedge clk);
    din = 128'h0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      din = {4{$urandom}};
      chk("bp_ov", 128'(ov), 128'b111);
      chk("bp_ir", 128'(ir), 128'b000);
      chk("bp_dout", dq[1], FIPS_OUT);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ov", 128'(ov), 128'b0);
    chk("bp_release_ir", 128'(ir), 128'b111);
    repeat (3) @(negedge clk);
    chk("bp_no_ghost", 128'(ov), 128'b0);

    // 5: reset mid-BUSY, then clean next block
    din = {16{8'hff}}; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 128'(ov), 128'b0);
    chk("mid_rst_dout4", dq[1], 128'h0);
    chk("mid_rst_dout1", dq[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ir", 128'(ir), 128'b111);
    run_blk("after_rst", {16{8'h01}}, {16{8'h7c}}, 1'b0, 1'b0);
    run_blk("ff", {16{8'hff}}, {16{8'h16}}, 1'b0, 1'b0);

`ifdef AES_SUB_BYTES_INV_EN
    // 6: inverse S-box, including inv toggling mid-operation
    run_blk("inv63", {16{8'h63}}, 128'h0, 1'b1, 1'b0);
    run_blk("inv16", {16{8'h16}}, {16{8'hff}}, 1'b1, 1'b0);
    run_blk("inv_tog", FIPS_OUT, FIPS_IN, 1'b1, 1'b1);
    run_blk("fwd_tog", FIPS_IN, FIPS_OUT, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/aes_sub_bytes_iter.md
Name: aes_sub_bytes_iter

Overview:
Iterative AES SubBytes stage. Sits directly upstream of the combinational shiftRows stage in the round datapath.
Accepts a 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through replicated S-box lookups. Presents the substituted 128-bit state, held stable until consumed.
Trades area (fewer S-box instances) for latency.

Parameters:
BYTES_PER_CYCLE, 4, S-box instances, i.e. bytes substituted per BUSY cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
din  input  128  state in; byte i = din[8i+7:8i], same byte mapping shiftRows consumes
in_valid  input  1  din valid
in_ready  output  1  block can accept din
dout  output  128  substituted state; byte i = S(din byte i)
out_valid  output  1  dout valid
out_ready  input  1  downstream accepts dout

Behaviour:
- N = 16 / BYTES_PER_CYCLE. Byte counter width is clog2(N), minimum 1 bit.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - in_valid && in_ready at edge: capture din into state register, cnt<=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0.
    - Each edge replaces bytes [cnt*BPC .. cnt*BPC+BPC-1] of the state register with their S-box value; cnt<=cnt+1.
    - After the edge where cnt==N-1, go to DONE; cnt wraps to 0.
  - DONE: out_valid=1, in_ready=0, dout = state register, held stable.
    - out_ready at edge: go to IDLE.
- dout is driven from the state register at all times. Its content is only meaningful while out_valid=1.
- Latency: accept at edge k, out_valid high after edge k+N; with BPC=4, 4 cycles.
- Throughput: one block per N+2 cycles minimum. There is no overlap of input accept and output hold.
- din is sampled only at the accept edge; later changes to din are ignored.
- in_valid while not IDLE: ignored. Upstream must hold the request until in_ready.
- out_ready while not DONE: ignored.
- out_ready held high continuously: DONE lasts exactly 1 cycle.
- S-box: FIPS-197 forward S-box, purely combinational per instance. Implementation is either a 256-entry table or composite-field logic; outputs must be bit-identical.
- Reset (asynchronous, any state, including mid-BUSY):
  - state -> IDLE, cnt=0, state register=0.
  - out_valid=0, in_ready=1 once rst_n deasserts; dout=0.
  - A partially substituted block is discarded.
- In-flight status: in_ready=0 while in BUSY or DONE.

Optional Feature:
Macro: AES_SUB_BYTES_INV_EN.
- Defined: extra port inv (input, 1).
  - Sampled and registered at the accept edge; held for the whole operation.
  - inv=1 selects the FIPS-197 inverse S-box for all bytes of that block; inv=0 selects the forward S-box.
  - Change of inv mid-BUSY has no effect.
- Not defined: no inv port; forward S-box only; no inverse table/logic synthesized.

Test Plan:
1. Reset then idle: rst_n=0 then 1 -> in_ready=1, out_valid=0, dout=128'h0.
2. Basic, BPC=4:
   - din=128'h0, in_valid one cycle -> out_valid exactly 4 cycles after accept.
   - dout=128'h63636363_63636363_63636363_63636363.
3. FIPS-197 round-1 vector:
   - din bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08.
   - Required dout bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
   - Repeat with BPC=1 (latency 16) and BPC=16 (latency 1); same dout.
4. Backpressure:
   - Hold out_ready=0 for 10 cycles after out_valid -> dout/out_valid stable, in_ready=0.
   - New in_valid ignored throughout.
   - out_ready=1 -> out_valid drops next cycle, in_ready=1.
5. Reset mid-BUSY:
   - Assert rst_n=0 two cycles after accepting all-0xFF -> out_valid=0, dout=0 immediately.
   - After release, next block all-0x01 -> dout all-0x7C (no stale bytes).
6. With AES_SUB_BYTES_INV_EN:
   - inv=1, din all-0x63 -> dout all-0x00.
   - inv=1, din all-0x16 -> dout all-0xFF.
   - inv toggled mid-BUSY -> result unchanged.
